load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data and address width (only 32 is supported).
REQ-002 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-004 SHALL have port Req_Valid_i  input  1: the pipeline presents a request.
REQ-005 SHALL have port Req_Ready_o  output  1: the unit can accept a request (IDLE only).
REQ-006 SHALL have port Req_Write_i  input  1: 1 = store, 0 = load.
REQ-007 SHALL have port Req_Size_i  input  2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 SHALL have port Req_Unsigned_i  input  1: zero-extend load data when 1.
REQ-009 SHALL have port Req_Address_i  input  32: byte address.
REQ-010 SHALL have port Req_Data_i  input  32: store data, right-aligned.
REQ-011 SHALL have port Rsp_Valid_o  output  1: one-cycle completion pulse.
REQ-012 SHALL have port Rsp_Data_o  output  32: load result; 0 for stores and errors.
REQ-013 SHALL have port Misaligned_o  output  1: error flag, valid with Rsp_Valid_o.
REQ-014 SHALL have ports Mem_Read_o, Mem_Write_o  output  1: word-memory strobes.
REQ-015 SHALL have ports Mem_Address_o, Mem_Write_Data_o  output  32: word-aligned byte address and write word.
REQ-016 SHALL have port Mem_Read_Data_i  input  32: combinational memory read word; memory writes on the clock edge.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, RMW_READ, STORE, RESP, ERR.
REQ-018 SHALL drive Req_Ready_o=1 only in IDLE; the request is accepted and all Req_* fields registered on a clk edge with Req_Valid_i=1 in IDLE.
REQ-019 SHALL ignore Req_Valid_i outside IDLE; the requester holds it.
REQ-020 SHALL transition from IDLE on accept: misaligned -> ERR; load -> LOAD; word store -> STORE; byte/half store -> RMW_READ.
REQ-021 SHALL define misaligned as: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
REQ-022 SHALL, in LOAD, assert Mem_Read_o, capture the extracted and extended data, then go to RESP.
REQ-023 SHALL, in RMW_READ, assert Mem_Read_o, merge the store lane into the captured word, then go to STORE.
REQ-024 SHALL, in STORE, assert Mem_Write_o for exactly one cycle with Mem_Write_Data_o = the full or merged word, then go to RESP.
REQ-025 SHALL, in RESP, pulse Rsp_Valid_o for one cycle and in ERR pulse Rsp_Valid_o and Misaligned_o for one cycle; both return to IDLE.
REQ-026 SHALL select the byte lane by addr[1:0] and the half lane by addr[1]; loads sign-extend unless Req_Unsigned_i=1.
REQ-027 SHALL drive Mem_Address_o = {addr[31:2], 2'b00} in memory states and 0 otherwise; strobes and Mem_Write_Data_o are 0 outside their states.
REQ-028 SHALL meet latency from accept edge T: error Rsp at T+1; load and word store at T+2; sub-word store at T+3.
REQ-029 SHALL produce Rsp_Data_o = 0 except in RESP following a load.

Reset
REQ-030 SHALL, on reset low, force IDLE immediately; all outputs 0 except Req_Ready_o=1.
REQ-031 SHALL, when reset arrives mid-operation, abort with no memory write and no Rsp_Valid_o pulse.

Configuration
REQ-032 SHALL, with LSU_MISALIGN_TRAP_EN defined, implement the ERR path of REQ-020/025.
REQ-033 SHALL, without LSU_MISALIGN_TRAP_EN, remove the ERR state: tie Misaligned_o to 0, force the illegal address bits to 0, and treat size 11 as word.

Verification (memory word 0x10 = 0x8899AABB)
REQ-034 SHALL cover: signed byte load at 0x11 -> Rsp_Data_o=0xFFFFFFAA at T+2, Mem_Read_o high at T+1 only.
REQ-035 SHALL cover: byte store 0x5A at 0x12 -> read at T+1, Mem_Write_Data_o=0x885AAABB at T+2, Rsp at T+3.
REQ-036 SHALL cover: unsigned half load at 0x12 -> Rsp_Data_o=0x00008899.
REQ-037 SHALL cover: word load at 0x13 with macro -> Rsp_Valid_o and Misaligned_o at T+1, no memory strobe; without macro -> 0x8899AABB at T+2.
REQ-038 SHALL cover: reset low during RMW_READ -> Mem_Write_o stays 0, word unchanged, Req_Ready_o=1 after release.
REQ-039 SHALL cover: Req_Valid_i held for two word stores -> second accepted in the first IDLE cycle after RESP, Req_Ready_o=0 in between.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads with sign or zero extension and
// sub-word stores by read-modify-write against a word-wide memory.
// Optional misalignment trap (ERR path) enabled by `define LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Req_Valid_i,
    output logic                  Req_Ready_o,
    input  logic                  Req_Write_i,
    input  logic [1:0]            Req_Size_i,
    input  logic                  Req_Unsigned_i,
    input  logic [DATA_WIDTH-1:0] Req_Address_i,
    input  logic [DATA_WIDTH-1:0] Req_Data_i,
    output logic                  Rsp_Valid_o,
    output logic [DATA_WIDTH-1:0] Rsp_Data_o,
    output logic                  Misaligned_o,
    output logic                  Mem_Read_o,
    output logic                  Mem_Write_o,
    output logic [DATA_WIDTH-1:0] Mem_Address_o,
    output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
    input  logic [DATA_WIDTH-1:0] Mem_Read_Data_i
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_READ,
        STORE,
        RESP
`ifdef LSU_MISALIGN_TRAP_EN
        , ERR
`endif
    } state_t;

    // Pick the addressed lane out of a memory word and extend it.
    function automatic logic [DATA_WIDTH-1:0] f_extract(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            off,
        input logic [1:0]            size,
        input logic                  uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: f_extract = {{(DATA_WIDTH-8){~uns & b[7]}}, b};
            SZ_HALF: f_extract = {{(DATA_WIDTH-16){~uns & h[15]}}, h};
            default: f_extract = word;
        endcase
    endfunction

    // Replace the addressed lane of a memory word with right-aligned store data.
    function automatic logic [DATA_WIDTH-1:0] f_merge(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            off,
        input logic [1:0]            size,
        input logic [DATA_WIDTH-1:0] data
    );
        logic [DATA_WIDTH-1:0] m;
        m = word;
        case (size)
            SZ_BYTE: m[{off, 3'b000} +: 8] = data[7:0];
            SZ_HALF: begin
                if (off[1]) m[31:16] = data[15:0];
                else        m[15:0]  = data[15:0];
            end
            default: m = data;
        endcase
        f_merge = m;
    endfunction

    state_t                r_state;
    logic                  r_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [DATA_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_write;
    logic [1:0]            r_size;
    logic                  r_uns;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;

    logic [1:0]            w_size_eff;
    logic [DATA_WIDTH-1:0] w_addr_eff;
    logic [DATA_WIDTH-1:0] w_load_ext;
    logic [DATA_WIDTH-1:0] w_merged;

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_misaligned;
    logic w_misaligned;

    assign w_size_eff   = Req_Size_i;
    assign w_addr_eff   = Req_Address_i;
    assign w_misaligned = (Req_Size_i == SZ_HALF && Req_Address_i[0])
                       || (Req_Size_i == SZ_WORD && |Req_Address_i[1:0])
                       || (Req_Size_i == SZ_ILL);
`else
    // No trap: illegal size behaves as word, offending low address bits drop.
    assign w_size_eff = (Req_Size_i == SZ_ILL) ? SZ_WORD : Req_Size_i;

    always_comb begin
        w_addr_eff = Req_Address_i;
        if (w_size_eff == SZ_HALF)      w_addr_eff[0]   = 1'b0;
        else if (w_size_eff == SZ_WORD) w_addr_eff[1:0] = 2'b00;
    end
`endif

    assign w_load_ext = f_extract(Mem_Read_Data_i, r_addr[1:0], r_size, r_uns);
    assign w_merged   = f_merge(Mem_Read_Data_i, r_addr[1:0], r_size, r_data);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_write     <= 1'b0;
            r_size      <= SZ_BYTE;
            r_uns       <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misaligned <= 1'b0;
`endif
        end else begin
            // Every output is a one-state pulse; default them low each cycle.
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misaligned <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (Req_Valid_i) begin
                        r_ready <= 1'b0;
                        r_write <= Req_Write_i;
                        r_size  <= w_size_eff;
                        r_uns   <= Req_Unsigned_i;
                        r_addr  <= w_addr_eff;
                        r_data  <= Req_Data_i;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (w_misaligned) begin
                            r_state      <= ERR;
                            r_rsp_valid  <= 1'b1;
                            r_misaligned <= 1'b1;
                        end else
`endif
                        if (!Req_Write_i) begin
                            r_state    <= LOAD;
                            r_mem_read <= 1'b1;
                            r_mem_addr <= {w_addr_eff[DATA_WIDTH-1:2], 2'b00};
                        end else if (w_size_eff == SZ_WORD) begin
                            r_state     <= STORE;
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= {w_addr_eff[DATA_WIDTH-1:2], 2'b00};
                            r_mem_wdata <= Req_Data_i;
                        end else begin
                            r_state    <= RMW_READ;
                            r_mem_read <= 1'b1;
                            r_mem_addr <= {w_addr_eff[DATA_WIDTH-1:2], 2'b00};
                        end
                    end
                end
                LOAD: begin
                    r_state     <= RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= r_write ? '0 : w_load_ext;
                end
                RMW_READ: begin
                    r_state     <= STORE;
                    r_mem_write <= 1'b1;
                    r_mem_addr  <= {r_addr[DATA_WIDTH-1:2], 2'b00};
                    r_mem_wdata <= w_merged;
                end
                STORE: begin
                    r_state     <= RESP;
                    r_rsp_valid <= 1'b1;
                end
                RESP: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
`ifdef LSU_MISALIGN_TRAP_EN
                ERR: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign Req_Ready_o      = r_ready;
    assign Rsp_Valid_o      = r_rsp_valid;
    assign Rsp_Data_o       = r_rsp_data;
    assign Mem_Read_o       = r_mem_read;
    assign Mem_Write_o      = r_mem_write;
    assign Mem_Address_o    = r_mem_addr;
    assign Mem_Write_Data_o = r_mem_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
    assign Misaligned_o = r_misaligned;
`else
    assign Misaligned_o = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written corner
// sequences (reset mid-RMW, back-to-back stores) and random traffic vs a model.
module tb_load_store_unit;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        Req_Valid_i = 1'b0;
    logic        Req_Ready_o;
    logic        Req_Write_i = 1'b0;
    logic [1:0]  Req_Size_i = 2'b00;
    logic        Req_Unsigned_i = 1'b0;
    logic [31:0] Req_Address_i = '0;
    logic [31:0] Req_Data_i = '0;
    logic        Rsp_Valid_o;
    logic [31:0] Rsp_Data_o;
    logic        Misaligned_o;
    logic        Mem_Read_o;
    logic        Mem_Write_o;
    logic [31:0] Mem_Address_o;
    logic [31:0] Mem_Write_Data_o;
    logic [31:0] Mem_Read_Data_i;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(rst_n),
        .Req_Valid_i(Req_Valid_i), .Req_Ready_o(Req_Ready_o),
        .Req_Write_i(Req_Write_i), .Req_Size_i(Req_Size_i),
        .Req_Unsigned_i(Req_Unsigned_i), .Req_Address_i(Req_Address_i),
        .Req_Data_i(Req_Data_i), .Rsp_Valid_o(Rsp_Valid_o),
        .Rsp_Data_o(Rsp_Data_o), .Misaligned_o(Misaligned_o),
        .Mem_Read_o(Mem_Read_o), .Mem_Write_o(Mem_Write_o),
        .Mem_Address_o(Mem_Address_o), .Mem_Write_Data_o(Mem_Write_Data_o),
        .Mem_Read_Data_i(Mem_Read_Data_i)
    );

    // Word memory the DUT talks to; the reference copy lives in ref_mem.
    logic [31:0] mem [0:15];
    logic [31:0] ref_mem [0:15];
    logic        init_req = 1'b0;
    int          wr_count = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h8899AABB;
        return 32'h0F1E2D3C + 32'h01010101 * i;
    endfunction

    assign Mem_Read_Data_i = mem[Mem_Address_o[5:2]];

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        end else if (Mem_Write_o) begin
            mem[Mem_Address_o[5:2]] <= Mem_Write_Data_o;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-lane arithmetic on ref_mem, strobe cycles as masks.
    task automatic model(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a_in, input logic [31:0] d,
                         output logic [31:0] e_data, output int e_lat, output logic e_mis,
                         output logic [7:0] e_rd, output logic [7:0] e_wr);
        int s, a, n, off, idx;
        longint word, lanemask, val, span;
        s = sz;
        a = int'(a_in % 64);
        e_data = '0; e_lat = 0; e_mis = 1'b0; e_rd = '0; e_wr = '0;
        if (TRAP && ((s == 1 && a % 2 != 0) || (s == 2 && a % 4 != 0) || s == 3)) begin
            e_mis = 1'b1;
            e_lat = 1;
            return;
        end
        if (s == 3) s = 2;
        n = 1 << s;
        a = a - a % n;
        idx = a / 4;
        off = a % 4;
        span = longint'(1) << (8 * n);
        word = longint'(ref_mem[idx]);
        if (!w) begin
            val = (word >> (8 * off)) % span;
            if (!uns && n < 4 && val >= span / 2) val = val - span;
            e_data = val[31:0];
            e_lat = 2;
            e_rd = 8'h02;
        end else begin
            lanemask = (span - 1) << (8 * off);
            word = (word & ~lanemask) | ((longint'(d) % span) << (8 * off));
            ref_mem[idx] = word[31:0];
            if (n == 4) begin
                e_lat = 2; e_wr = 8'h02;
            end else begin
                e_lat = 3; e_rd = 8'h02; e_wr = 8'h04;
            end
        end
    endtask

    // Issue one request and watch up to 6 cycles after the accept edge.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rd, output logic mis,
                           output logic [7:0] rmask, output logic [7:0] wmask,
                           output logic side_ok);
        @(negedge clk);
        Req_Valid_i = 1'b1; Req_Write_i = w; Req_Size_i = sz;
        Req_Unsigned_i = uns; Req_Address_i = a; Req_Data_i = d;
        side_ok = Req_Ready_o;
        @(posedge clk);
        lat = 0; rd = '0; mis = 1'b0; rmask = '0; wmask = '0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            Req_Valid_i = 1'b0;
            if (Mem_Read_o) rmask[k] = 1'b1;
            if (Mem_Write_o) wmask[k] = 1'b1;
            if (Mem_Read_o || Mem_Write_o) begin
                if (Mem_Address_o != {a[31:2], 2'b00}) side_ok = 1'b0;
            end else if (Mem_Address_o != 0 || Mem_Write_Data_o != 0) side_ok = 1'b0;
            if (Req_Ready_o) side_ok = 1'b0;
            if (Rsp_Valid_o) begin
                lat = k; rd = Rsp_Data_o; mis = Misaligned_o;
            end else if (Rsp_Data_o != 0 || Misaligned_o) side_ok = 1'b0;
        end
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        int          lat;
        logic        mis;
    } vec_t;

    vec_t tbl [16];

    task automatic apply_and_check(input string tag, input logic w, input logic [1:0] sz,
                                   input logic uns, input logic [31:0] a, input logic [31:0] d,
                                   input logic use_tbl, input logic [31:0] t_exp,
                                   input int t_lat, input logic t_mis);
        logic [31:0] e_data, rd;
        int          e_lat, lat;
        logic        e_mis, mis, side_ok;
        logic [7:0]  e_rd, e_wr, rmask, wmask;
        model(w, sz, uns, a, d, e_data, e_lat, e_mis, e_rd, e_wr);
        if (use_tbl) begin
            e_data = t_exp; e_lat = t_lat; e_mis = t_mis;
        end
        run_req(w, sz, uns, a, d, lat, rd, mis, rmask, wmask, side_ok);
        chk({tag, " latency"}, lat, e_lat);
        chk({tag, " rsp_data"}, rd, e_data);
        chk({tag, " misaligned"}, {31'b0, mis}, {31'b0, e_mis});
        chk({tag, " read_cycles"}, {24'b0, rmask}, {24'b0, e_rd});
        chk({tag, " write_cycles"}, {24'b0, wmask}, {24'b0, e_wr});
        chk({tag, " quiet_outputs"}, {31'b0, side_ok}, 32'd1);
        chk({tag, " mem_word"}, mem[a[5:2]], ref_mem[a[5:2]]);
    endtask

    initial begin
        int          wc;
        logic [31:0] dd;
        int          dl;
        logic        dm;
        logic [7:0]  d1, d2;

        tbl[0]  = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'hFFFFFFAA, 2, 1'b0};
        tbl[1]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h00008899, 2, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h00000088, 2, 1'b0};
        tbl[3]  = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 32'hFFFFAABB, 2, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'hFFFFFFBB, 2, 1'b0};
        tbl[5]  = '{1'b1, 2'd0, 1'b0, 32'h12, 32'h5A, 32'h0, 3, 1'b0};
        tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h885AAABB, 2, 1'b0};
        tbl[7]  = '{1'b1, 2'd1, 1'b0, 32'h10, 32'hFFFF1234, 32'h0, 3, 1'b0};
        tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h885A1234, 2, 1'b0};
        tbl[9]  = '{1'b1, 2'd2, 1'b0, 32'h14, 32'hDEADBEEF, 32'h0, 2, 1'b0};
        tbl[10] = '{1'b0, 2'd0, 1'b0, 32'h17, 32'h0, 32'hFFFFFFDE, 2, 1'b0};
        tbl[11] = '{1'b0, 2'd1, 1'b0, 32'h16, 32'h0, 32'hFFFFDEAD, 2, 1'b0};
        tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h13, 32'h0, TRAP ? 32'h0 : 32'h885A1234, TRAP ? 1 : 2, TRAP};
        tbl[13] = '{1'b1, 2'd1, 1'b0, 32'h11, 32'h7777, 32'h0, TRAP ? 1 : 3, TRAP};
        tbl[14] = '{1'b0, 2'd3, 1'b0, 32'h14, 32'h0, TRAP ? 32'h0 : 32'hDEADBEEF, TRAP ? 1 : 2, TRAP};
        tbl[15] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, TRAP ? 32'h885A1234 : 32'h885A7777, 2, 1'b0};

        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);

        // Reset state
        #2 rst_n = 1'b0;
        @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        chk("reset ready", {31'b0, Req_Ready_o}, 32'd1);
        chk("reset rsp_valid", {31'b0, Rsp_Valid_o}, 32'd0);
        chk("reset rsp_data", Rsp_Data_o, 32'd0);
        chk("reset misaligned", {31'b0, Misaligned_o}, 32'd0);
        chk("reset strobes", {30'b0, Mem_Read_o, Mem_Write_o}, 32'd0);
        chk("reset mem_addr", Mem_Address_o, 32'd0);
        chk("reset mem_wdata", Mem_Write_Data_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++)
            apply_and_check($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].uns,
                            tbl[i].a, tbl[i].d, 1'b1, tbl[i].exp, tbl[i].lat, tbl[i].mis);

        // Reset arriving while the read half of a read-modify-write is in flight
        wc = wr_count;
        @(negedge clk);
        Req_Valid_i = 1'b1; Req_Write_i = 1'b1; Req_Size_i = 2'd0;
        Req_Unsigned_i = 1'b0; Req_Address_i = 32'h12; Req_Data_i = 32'hA5;
        @(posedge clk);
        @(negedge clk);
        Req_Valid_i = 1'b0;
        chk("rst_mid in rmw_read", {31'b0, Mem_Read_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid ready immediate", {31'b0, Req_Ready_o}, 32'd1);
        chk("rst_mid read dropped", {31'b0, Mem_Read_o}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_mid held write", {31'b0, Mem_Write_o}, 32'd0);
            chk("rst_mid held rsp", {31'b0, Rsp_Valid_o}, 32'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_mid post write", {31'b0, Mem_Write_o}, 32'd0);
            chk("rst_mid post rsp", {31'b0, Rsp_Valid_o}, 32'd0);
            chk("rst_mid post ready", {31'b0, Req_Ready_o}, 32'd1);
        end
        chk("rst_mid word unchanged", mem[4], ref_mem[4]);
        chk("rst_mid no writes", wr_count, wc);

        // Requester holds Req_Valid_i across two word stores
        model(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, dd, dl, dm, d1, d2);
        model(1'b1, 2'd2, 1'b0, 32'h24, 32'h55667788, dd, dl, dm, d1, d2);
        @(negedge clk);
        Req_Valid_i = 1'b1; Req_Write_i = 1'b1; Req_Size_i = 2'd2;
        Req_Address_i = 32'h20; Req_Data_i = 32'h11223344;
        chk("b2b ready before", {31'b0, Req_Ready_o}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        Req_Address_i = 32'h24; Req_Data_i = 32'h55667788;
        chk("b2b T1 ready", {31'b0, Req_Ready_o}, 32'd0);
        chk("b2b T1 write", {31'b0, Mem_Write_o}, 32'd1);
        @(negedge clk);
        chk("b2b T2 ready", {31'b0, Req_Ready_o}, 32'd0);
        chk("b2b T2 rsp", {31'b0, Rsp_Valid_o}, 32'd1);
        @(negedge clk);
        chk("b2b T3 idle ready", {31'b0, Req_Ready_o}, 32'd1);
        @(negedge clk);
        chk("b2b T4 write", {31'b0, Mem_Write_o}, 32'd1);
        chk("b2b T4 addr", Mem_Address_o, 32'h24);
        chk("b2b T4 ready", {31'b0, Req_Ready_o}, 32'd0);
        @(negedge clk);
        Req_Valid_i = 1'b0;
        chk("b2b T5 rsp", {31'b0, Rsp_Valid_o}, 32'd1);
        @(negedge clk);
        chk("b2b T6 ready", {31'b0, Req_Ready_o}, 32'd1);
        chk("b2b word0", mem[8], ref_mem[8]);
        chk("b2b word1", mem[9], ref_mem[9]);

        // Random traffic against the reference model
        for (int i = 0; i < 200; i++) begin
            logic        rw, ru;
            logic [1:0]  rs;
            logic [31:0] ra, rdat;
            rw = 1'($urandom_range(0, 1));
            rs = 2'($urandom_range(0, 3));
            ru = 1'($urandom_range(0, 1));
            ra = 32'($urandom_range(0, 63));
            rdat = $urandom;
            apply_and_check($sformatf("rand%0d", i), rw, rs, ru, ra, rdat,
                            1'b0, 32'h0, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
